// File: rtl/image_capture.sv
// Capture engine: packs an 8-bit grayscale pixel stream into 32-bit words and writes them out
// through an Avalon-MM write master. Optional drop counter: define IMAGE_CAPTURE_DROP_CNT_EN.
module image_capture #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_capture,
  input  logic [23:0] capture_imgsize,
  input  logic [31:0] buff,
  output logic        image_captured,
  output logic        capture_standby,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        overflow
`ifdef IMAGE_CAPTURE_DROP_CNT_EN
  ,output logic [15:0] drop_count
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 54;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_SOF = 3'd1;
  localparam logic [2:0] S_CAPTURE  = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             start_prev_q;
  logic [21:0]      total_words_q, total_words_d;
  logic [31:0]      base_q, base_d;
  logic [21:0]      word_idx_q, word_idx_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      pack_q, pack_d;
  logic             stg_vld_q, stg_vld_d;
  logic [21:0]      stg_idx_q, stg_idx_d;
  logic [31:0]      stg_data_q, stg_data_d;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]    fifo_mem [DEPTH];
  logic             avm_write_q;
  logic [31:0]      avm_address_q;
  logic [31:0]      avm_writedata_q;
  logic [3:0]       avm_byteenable_q;
  logic             image_captured_q;
  logic             capture_standby_q;
  logic             overflow_q;

  logic             edge_s;
  logic             leave_idle_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             xfer_done_s;
  logic [EW-1:0]    rd_entry_s;
  logic             unused_s;

  assign unused_s     = ^{capture_imgsize[1:0], buff[1:0]};
  assign edge_s       = start_capture & ~start_prev_q;
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign xfer_done_s  = avm_write_q & ~avm_waitrequest;
  // A new word is only presented once the previous transfer has fully retired.
  assign pop_s        = ~fifo_empty_s & ~avm_write_q;
  assign push_s       = stg_vld_q & (~fifo_full_s | pop_s);
  assign drop_s       = stg_vld_q & fifo_full_s & ~pop_s;
  assign rd_entry_s   = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

  // Capture FSM, pixel packing and staging of completed words
  always_comb begin
    state_d       = state_q;
    total_words_d = total_words_q;
    base_d        = base_q;
    word_idx_d    = word_idx_q;
    byte_cnt_d    = byte_cnt_q;
    pack_d        = pack_q;
    stg_vld_d     = 1'b0;
    stg_idx_d     = stg_idx_q;
    stg_data_d    = stg_data_q;
    leave_idle_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edge_s) begin
          total_words_d = capture_imgsize[23:2];
          base_d        = {buff[31:2], 2'b00};
          word_idx_d    = 22'd0;
          byte_cnt_d    = 2'd0;
          pack_d        = 24'd0;
          leave_idle_s  = 1'b1;
          if (capture_imgsize[23:2] == 22'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_SOF;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_SOF: begin
        if (in_valid && in_sof) begin
          pack_d     = {16'h0000, in_data};
          byte_cnt_d = 2'd1;
          state_d    = S_CAPTURE;
        end else begin
          state_d = S_WAIT_SOF;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          if (byte_cnt_q == 2'd3) begin
            stg_vld_d  = 1'b1;
            stg_idx_d  = word_idx_q;
            stg_data_d = {in_data, pack_q};
            word_idx_d = word_idx_q + 22'd1;
            byte_cnt_d = 2'd0;
            pack_d     = 24'd0;
            if ((word_idx_q + 22'd1) == total_words_q) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    pack_d[7:0]   = in_data;
              2'd1:    pack_d[15:8]  = in_data;
              2'd2:    pack_d[23:16] = in_data;
              default: pack_d        = pack_q;
            endcase
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_FLUSH: begin
        if (!stg_vld_q && fifo_empty_s && !avm_write_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, pointer and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      start_prev_q      <= 1'b0;
      total_words_q     <= 22'd0;
      base_q            <= 32'd0;
      word_idx_q        <= 22'd0;
      byte_cnt_q        <= 2'd0;
      pack_q            <= 24'd0;
      stg_vld_q         <= 1'b0;
      stg_idx_q         <= 22'd0;
      stg_data_q        <= 32'd0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      image_captured_q  <= 1'b0;
      capture_standby_q <= 1'b1;
      overflow_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      start_prev_q      <= start_capture;
      total_words_q     <= total_words_d;
      base_q            <= base_d;
      word_idx_q        <= word_idx_d;
      byte_cnt_q        <= byte_cnt_d;
      pack_q            <= pack_d;
      stg_vld_q         <= stg_vld_d;
      stg_idx_q         <= stg_idx_d;
      stg_data_q        <= stg_data_d;
      image_captured_q  <= (state_q == S_DONE);
      capture_standby_q <= (state_d == S_IDLE);
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
      end
      // Dropped words keep their index, so later words still land at the right address.
      if (leave_idle_s) begin
        overflow_q <= 1'b0;
      end else if (drop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage (contents are don't-care while the pointers are equal)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {stg_idx_q, stg_data_q};
    end
  end

  // Avalon-MM master output registers, held stable while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_write_q      <= 1'b0;
      avm_address_q    <= 32'd0;
      avm_writedata_q  <= 32'd0;
      avm_byteenable_q <= 4'h0;
    end else if (pop_s) begin
      avm_write_q      <= 1'b1;
      avm_address_q    <= base_q + {8'h00, rd_entry_s[53:32], 2'b00};
      avm_writedata_q  <= rd_entry_s[31:0];
      avm_byteenable_q <= 4'hF;
    end else if (xfer_done_s) begin
      avm_write_q      <= 1'b0;
      avm_byteenable_q <= 4'h0;
    end
  end

`ifdef IMAGE_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_count_q;

  // Saturating count of words dropped on a full FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_q <= 16'd0;
    end else if (leave_idle_s) begin
      drop_count_q <= 16'd0;
    end else if (drop_s && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`endif

  assign image_captured  = image_captured_q;
  assign capture_standby = capture_standby_q;
  assign avm_address     = avm_address_q;
  assign avm_write       = avm_write_q;
  assign avm_writedata   = avm_writedata_q;
  assign avm_byteenable  = avm_byteenable_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_image_capture.sv
// Directed self-checking bench for image_capture: expected words and addresses are hand-derived.
module tb_image_capture;

  logic        clk;
  logic        reset_n;
  logic        start_capture;
  logic [23:0] capture_imgsize;
  logic [31:0] buff;
  logic        image_captured;
  logic        capture_standby;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        overflow;
`ifdef IMAGE_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  image_capture #(.FIFO_AW(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_capture   (start_capture),
    .capture_imgsize (capture_imgsize),
    .buff            (buff),
    .image_captured  (image_captured),
    .capture_standby (capture_standby),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_sof          (in_sof),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .overflow        (overflow)
`ifdef IMAGE_CAPTURE_DROP_CNT_EN
    ,.drop_count     (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  // Record completed write transfers and image_captured pulses mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_write && !avm_waitrequest) begin
        wr_addr_q.push_back(avm_address);
        wr_data_q.push_back(avm_writedata);
      end
      if (image_captured) pulses++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] exp_word(input int first);
    return {8'(first + 3), 8'(first + 2), 8'(first + 1), 8'(first)};
  endfunction

  task automatic arm(input logic [23:0] size, input logic [31:0] base);
    capture_imgsize = size;
    buff            = base;
    start_capture   = 1'b1;
    step();
    start_capture   = 1'b0;
  endtask

  task automatic pixel(input int val, input logic sof);
    in_valid = 1'b1;
    in_data  = 8'(val);
    in_sof   = sof;
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int t = 0;
    while (image_captured !== 1'b1 && t < max_cyc) begin
      step();
      t++;
    end
    check_eq({tag, "_pulse"}, 32'(image_captured), 32'd1);
    check_eq({tag, "_standby"}, 32'(capture_standby), 32'd1);
    step();
    check_eq({tag, "_pulse_1cyc"}, 32'(image_captured), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] base, input int first);
    check_eq({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      check_eq($sformatf("%s_addr%0d", tag, k), wr_addr_q[k], base + 32'(4 * k));
      check_eq($sformatf("%s_data%0d", tag, k), wr_data_q[k], exp_word(first + 4 * k));
    end
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; start_capture = 1'b0; capture_imgsize = 24'd0; buff = 32'd0;
    in_data = 8'd0; in_valid = 1'b0; in_sof = 1'b0; avm_waitrequest = 1'b0;
    repeat (3) step();
    check_eq("rst_captured", 32'(image_captured), 32'd0);
    check_eq("rst_standby", 32'(capture_standby), 32'd1);
    check_eq("rst_write", 32'(avm_write), 32'd0);
    check_eq("rst_addr", avm_address, 32'd0);
    check_eq("rst_data", avm_writedata, 32'd0);
    check_eq("rst_be", 32'(avm_byteenable), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();

    // Basic 16-byte capture with unaligned base
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    arm(24'd16, 32'h1000_0003);
    check_eq("basic_standby_low", 32'(capture_standby), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pixel(i, i == 0);
      if (i == 4) check_eq("lat_cyc1", 32'(avm_write), 32'd0);
      if (i == 5) begin
        check_eq("lat_cyc2", 32'(avm_write), 32'd1);
        check_eq("basic_be", 32'(avm_byteenable), 32'hF);
      end
    end
    wait_done("basic", 100);
    check_writes("basic", 4, 32'h1000_0000, 0);
    check_eq("basic_npulse", 32'(pulses - p0), 32'd1);

    // Zero-size capture: pulse two cycles after the arming edge
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    arm(24'd3, 32'h2000_0000);
    check_eq("zero_cap_c1", 32'(image_captured), 32'd0);
    check_eq("zero_standby_c1", 32'(capture_standby), 32'd0);
    step();
    check_eq("zero_cap_c2", 32'(image_captured), 32'd1);
    step();
    check_eq("zero_cap_c3", 32'(image_captured), 32'd0);
    check_eq("zero_standby_c3", 32'(capture_standby), 32'd1);
    for (int i = 0; i < 8; i++) pixel(8'h60 + i, i == 0);
    repeat (4) step();
    check_eq("zero_nwr", 32'(wr_addr_q.size()), 32'd0);
    check_eq("zero_npulse", 32'(pulses - p0), 32'd1);

    // SOF gating and trailing pixels
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    arm(24'd8, 32'h0000_0100);
    for (int i = 0; i < 5; i++) pixel(8'hA0 + i, 1'b0);
    for (int i = 0; i < 8; i++) pixel(8'h10 + i, i == 0);
    for (int i = 0; i < 4; i++) pixel(8'hE0 + i, 1'b0);
    wait_done("sof", 100);
    check_writes("sof", 2, 32'h0000_0100, 8'h10);
    check_eq("sof_npulse", 32'(pulses - p0), 32'd1);

    // Backpressure: word 0 in the output register, words 1..16 in the FIFO, 17..31 dropped
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    avm_waitrequest = 1'b1;
    arm(24'd128, 32'h0000_4000);
    check_eq("bp_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 128; i++) pixel(i, i == 0);
    repeat (71) step();
    check_eq("bp_ovf_set", 32'(overflow), 32'd1);
    check_eq("bp_stall_write", 32'(avm_write), 32'd1);
    check_eq("bp_stall_addr", avm_address, 32'h0000_4000);
    check_eq("bp_nwr_stalled", 32'(wr_addr_q.size()), 32'd0);
    avm_waitrequest = 1'b0;
    wait_done("bp", 500);
    check_writes("bp", 17, 32'h0000_4000, 0);
    check_eq("bp_ovf_sticky", 32'(overflow), 32'd1);
    check_eq("bp_npulse", 32'(pulses - p0), 32'd1);

    // Second start edge mid-capture and early start release are ignored
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    arm(24'd8, 32'h0000_0200);
    check_eq("restart_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start_capture = 1'b1;
      if (i == 4) start_capture = 1'b0;
      pixel(8'h40 + i, i == 0);
    end
    wait_done("restart", 100);
    check_writes("restart", 2, 32'h0000_0200, 8'h40);
    check_eq("restart_npulse", 32'(pulses - p0), 32'd1);

    // Reset while a stalled transfer is pending
    wr_addr_q.delete(); wr_data_q.delete();
    avm_waitrequest = 1'b1;
    arm(24'd8, 32'h0000_0300);
    for (int i = 0; i < 4; i++) pixel(8'h30 + i, i == 0);
    repeat (2) step();
    check_eq("rstmid_write_before", 32'(avm_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_write", 32'(avm_write), 32'd0);
    check_eq("rstmid_standby", 32'(capture_standby), 32'd1);
    check_eq("rstmid_captured", 32'(image_captured), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    step();
    wr_addr_q.delete(); wr_data_q.delete(); p0 = pulses;
    arm(24'd4, 32'h0000_0500);
    for (int i = 0; i < 4; i++) pixel(8'h50 + i, i == 0);
    wait_done("post_rst", 100);
    check_writes("post_rst", 1, 32'h0000_0500, 8'h50);
    check_eq("post_rst_npulse", 32'(pulses - p0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
